// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store master between a pipeline
// request port and a synchronous-write, combinational-read data memory.
// Requests are latched on acceptance. Aligned accesses take one memory cycle.
// Illegal sizes answer with an error and never touch memory.
// Build option LSU_MISALIGN_SPLIT_EN: when defined, misaligned half/word
// accesses are split into consecutive byte beats and the load bytes are merged.
// When undefined, those accesses answer with an error.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | ready for a request; memory port parked
//   ST_ACCESS | single aligned memory cycle (byte/half/word)
//   ST_SPLIT  | byte beat k of a misaligned access (split build only)
//   ST_RESP   | one-cycle response strobe, then back to ST_IDLE

module lsu_mem_master #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy,
   output logic              mem_wr_en,
   output logic [1:0]        mem_data_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wr_data,
   input  logic [31:0]       mem_rd_data
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_SPLIT  = 2'd2,
`endif
      ST_RESP   = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic              wr_q,    wr_d;
   logic [1:0]        size_q,  size_d;
   logic              uns_q,   uns_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       data_q,  data_d;
   logic              err_q,   err_d;
   logic [31:0]       load_ext;

`ifdef LSU_MISALIGN_SPLIT_EN
   logic [1:0]        beat_q,  beat_d;
   logic              split_last;
`endif

   logic req_illegal;
   logic req_misaligned;

   assign req_illegal    = (req_size == 2'b11);
   assign req_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                           ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_SPLIT_EN
   // a half needs beats 0..1, a word beats 0..3
   assign split_last = (size_q == 2'b01) ? (beat_q == 2'd1) : (beat_q == 2'd3);
`endif

   // state register; reset aborts any access in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_illegal) begin
                  state_d = ST_RESP;
               end else if (req_misaligned) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                  state_d = ST_SPLIT;
`else
                  state_d = ST_RESP;
`endif
               end else begin
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: state_d = ST_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
         ST_SPLIT: begin
            if (split_last) begin
               state_d = ST_RESP;
            end
         end
`endif
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // latched request fields and captured load data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
         beat_q  <= 2'd0;
`endif
      end else begin
         wr_q    <= wr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         err_q   <= err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
         beat_q  <= beat_d;
`endif
      end
   end

   // request capture on acceptance, read-data capture / byte merge per beat
   always_comb begin
      wr_d    = wr_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      err_d   = err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
      beat_d  = beat_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               wr_d    = req_wr;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               data_d  = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
               err_d   = req_illegal;
               beat_d  = 2'd0;
`else
               err_d   = req_illegal || req_misaligned;
`endif
            end
         end
         ST_ACCESS: begin
            if (!wr_q) begin
               data_d = mem_rd_data;
            end
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         ST_SPLIT: begin
            if (!wr_q) begin
               data_d[{beat_q, 3'b000} +: 8] = mem_rd_data[7:0];
            end
            beat_d = beat_q + 2'd1;
         end
`endif
         default: ;
      endcase
   end

   // zero/sign extension of the captured load data
   always_comb begin
      case (size_q)
         2'b00:   load_ext = uns_q ? {24'h0, data_q[7:0]}
                                   : {{24{data_q[7]}}, data_q[7:0]};
         2'b01:   load_ext = uns_q ? {16'h0, data_q[15:0]}
                                   : {{16{data_q[15]}}, data_q[15:0]};
         default: load_ext = data_q;
      endcase
   end

   // state-decoded outputs; memory port parked outside the access states
   always_comb begin
      req_ready     = (state_q == ST_IDLE);
      busy          = (state_q != ST_IDLE);
      resp_valid    = 1'b0;
      resp_err      = 1'b0;
      resp_rdata    = '0;
      mem_wr_en     = 1'b0;
      mem_data_size = 2'b10;
      mem_addr      = '0;
      mem_wr_data   = '0;
      case (state_q)
         ST_ACCESS: begin
            mem_wr_en     = wr_q;
            mem_data_size = size_q;
            mem_addr      = addr_q;
            mem_wr_data   = wdata_q;
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         ST_SPLIT: begin
            mem_wr_en     = wr_q;
            mem_data_size = 2'b00;
            mem_addr      = addr_q + ADDR_W'(beat_q);
            mem_wr_data   = {24'h0, wdata_q[{beat_q, 3'b000} +: 8]};
         end
`endif
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            if (!wr_q && !err_q) begin
               resp_rdata = load_ext;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a 1 KiB byte memory model
// (address bits [9:0]). Expectations follow LSU_MISALIGN_SPLIT_EN when defined.

module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wr = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;
   logic        mem_wr_en;
   logic [1:0]  mem_data_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      logic        wr;
      int          cyc;
   } acc_t;

   exp_t      sb[$];
   acc_t      alog[$];
   exp_t      mon_e;
   int        checks = 0;
   int        failures = 0;
   int        cyc = 0;
   bit [7:0]  mem [0:1023];

   lsu_mem_master #(.ADDR_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_wr        (req_wr),
      .req_size      (req_size),
      .req_unsigned  (req_unsigned),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .resp_err      (resp_err),
      .busy          (busy),
      .mem_wr_en     (mem_wr_en),
      .mem_data_size (mem_data_size),
      .mem_addr      (mem_addr),
      .mem_wr_data   (mem_wr_data),
      .mem_rd_data   (mem_rd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // memory model: combinational little-endian read, sized write on the edge
   always_comb begin
      mem_rd_data = {mem[mem_addr[9:0] + 10'd3], mem[mem_addr[9:0] + 10'd2],
                     mem[mem_addr[9:0] + 10'd1], mem[mem_addr[9:0]]};
   end

   always @(posedge clk) begin
      if (mem_wr_en) begin
         mem[mem_addr[9:0]] <= mem_wr_data[7:0];
         if (mem_data_size != 2'b00) mem[mem_addr[9:0] + 10'd1] <= mem_wr_data[15:8];
         if (mem_data_size == 2'b10) begin
            mem[mem_addr[9:0] + 10'd2] <= mem_wr_data[23:16];
            mem[mem_addr[9:0] + 10'd3] <= mem_wr_data[31:24];
         end
      end
   end

   // access log of every memory-driving cycle
   always @(negedge clk) begin
      if (!rst && ((busy && !resp_valid) || mem_wr_en))
         alog.push_back('{addr: mem_addr, data: mem_wr_data, size: mem_data_size,
                          wr: mem_wr_en, cyc: cyc});
   end

   // response monitor against the scoreboard
   always @(negedge clk) begin
      if (resp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected: resp_valid=1 at cycle %0d, required no response", cyc);
         end else begin
            mon_e = sb.pop_front();
            checks += 3;
            if (resp_rdata !== mon_e.rdata) begin
               failures++;
               $display("FAIL resp_rdata: got %08h, required %08h", resp_rdata, mon_e.rdata);
            end
            if (resp_err !== mon_e.err) begin
               failures++;
               $display("FAIL resp_err: got %0b, required %0b", resp_err, mon_e.err);
            end
            if (cyc != mon_e.due) begin
               failures++;
               $display("FAIL resp_latency: response at cycle %0d, required cycle %0d", cyc, mon_e.due);
            end
         end
      end
   end

   function automatic logic [31:0] mem_word(input logic [9:0] a);
      return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
   endfunction

   // drive one request, wait for acceptance, scramble req_* afterwards
   task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic push, input logic [31:0] exp_rd,
                        input logic exp_err, input int lat, output int acc);
      int n;
      @(negedge clk);
      req_wr = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, n);
      end
      @(posedge clk);
      #1;
      acc = cyc;
      req_valid = 1'b0;
      req_wr = 1'($urandom);
      req_size = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr = $urandom;
      req_wdata = $urandom;
      if (push) sb.push_back('{rdata: exp_rd, err: exp_err, due: acc + lat - 1});
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks += 9;
      if (req_ready !== 1'b1)    begin failures++; $display("FAIL rst_req_ready: got %0b, required 1", req_ready); end
      if (resp_valid !== 1'b0)   begin failures++; $display("FAIL rst_resp_valid: got %0b, required 0", resp_valid); end
      if (resp_err !== 1'b0)     begin failures++; $display("FAIL rst_resp_err: got %0b, required 0", resp_err); end
      if (resp_rdata !== 32'h0)  begin failures++; $display("FAIL rst_resp_rdata: got %08h, required 0", resp_rdata); end
      if (busy !== 1'b0)         begin failures++; $display("FAIL rst_busy: got %0b, required 0", busy); end
      if (mem_wr_en !== 1'b0)    begin failures++; $display("FAIL rst_mem_wr_en: got %0b, required 0", mem_wr_en); end
      if (mem_addr !== 32'h0)    begin failures++; $display("FAIL rst_mem_addr: got %08h, required 0", mem_addr); end
      if (mem_wr_data !== 32'h0) begin failures++; $display("FAIL rst_mem_wr_data: got %08h, required 0", mem_wr_data); end
      if (mem_data_size !== 2'b10) begin failures++; $display("FAIL rst_mem_size: got %0b, required 10", mem_data_size); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_store_load_word();
      int acc;
      alog.delete();
      issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 2, acc);
      drain();
      checks++;
      if (alog.size() != 1 || alog[0].wr !== 1'b1 || alog[0].size !== 2'b10 ||
          alog[0].addr !== 32'h100 || alog[0].data !== 32'hDEADBEEF || alog[0].cyc != acc) begin
         failures++;
         $display("FAIL store_word_access: %0d log entries (first wr=%0b size=%0b addr=%08h data=%08h), required 1 write size 10 @00000100 data deadbeef",
                  alog.size(), alog.size() ? alog[0].wr : 1'b0, alog.size() ? alog[0].size : 2'b0,
                  alog.size() ? alog[0].addr : 32'h0, alog.size() ? alog[0].data : 32'h0);
      end
      alog.delete();
      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2, acc);
      drain();
      checks++;
      if (alog.size() != 1 || alog[0].wr !== 1'b0 || alog[0].addr !== 32'h100) begin
         failures++;
         $display("FAIL load_word_access: %0d log entries, required 1 read @00000100", alog.size());
      end
   endtask

   task automatic test_load_extend();
      int acc;
      alog.delete();
      issue(1'b1, 2'b00, 1'b0, 32'h7, 32'hFFFFFF80, 1'b1, 32'h0, 1'b0, 2, acc);
      drain();
      checks++;
      if (alog.size() != 1 || alog[0].size !== 2'b00 || alog[0].addr !== 32'h7) begin
         failures++;
         $display("FAIL store_byte_access: %0d log entries, required 1 byte write @00000007", alog.size());
      end
      checks++;
      if (mem[8] !== 8'h00) begin
         failures++;
         $display("FAIL store_byte_spill: mem[8]=%02h, required 00", mem[8]);
      end
      issue(1'b0, 2'b00, 1'b0, 32'h7,  32'h0, 1'b1, 32'hFFFFFF80, 1'b0, 2, acc);
      issue(1'b0, 2'b00, 1'b1, 32'h7,  32'h0, 1'b1, 32'h00000080, 1'b0, 2, acc);
      issue(1'b1, 2'b01, 1'b0, 32'h10, 32'hABCD8001, 1'b1, 32'h0, 1'b0, 2, acc);
      issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b1, 32'hFFFF8001, 1'b0, 2, acc);
      issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b1, 32'h00008001, 1'b0, 2, acc);
      issue(1'b1, 2'b00, 1'b0, 32'h9,  32'h0000007F, 1'b1, 32'h0, 1'b0, 2, acc);
      issue(1'b0, 2'b00, 1'b0, 32'h9,  32'h0, 1'b1, 32'h0000007F, 1'b0, 2, acc);
      issue(1'b0, 2'b10, 1'b0, 32'h4,  32'h0, 1'b1, 32'h80000000, 1'b0, 2, acc);
      issue(1'b0, 2'b00, 1'b1, 32'h8,  32'h0, 1'b1, 32'h00000000, 1'b0, 2, acc);
      drain();
   endtask

   task automatic test_misaligned_store();
      int acc;
      alog.delete();
`ifdef LSU_MISALIGN_SPLIT_EN
      issue(1'b1, 2'b10, 1'b0, 32'h103, 32'h11223344, 1'b1, 32'h0, 1'b0, 5, acc);
      drain();
      checks++;
      if (alog.size() != 4) begin
         failures++;
         $display("FAIL split_store_beats: %0d beats, required 4", alog.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (alog[k].wr !== 1'b1 || alog[k].size !== 2'b00 || alog[k].addr !== 32'h103 + k ||
                alog[k].data !== ((32'h11223344 >> (8 * k)) & 32'hFF) || alog[k].cyc != acc + k) begin
               failures++;
               $display("FAIL split_store_beat%0d: wr=%0b size=%0b addr=%08h data=%08h cyc=%0d, required wr=1 size=00 addr=%08h data=%08h cyc=%0d",
                        k, alog[k].wr, alog[k].size, alog[k].addr, alog[k].data, alog[k].cyc,
                        32'h103 + k, (32'h11223344 >> (8 * k)) & 32'hFF, acc + k);
            end
         end
      end
      checks++;
      if (mem_word(10'h104) !== 32'h00112233 || mem[10'h103] !== 8'h44) begin
         failures++;
         $display("FAIL split_store_mem: word@104=%08h byte@103=%02h, required 00112233 / 44",
                  mem_word(10'h104), mem[10'h103]);
      end
`else
      issue(1'b1, 2'b10, 1'b0, 32'h103, 32'h11223344, 1'b1, 32'h0, 1'b1, 1, acc);
      issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1'b1, 32'h0, 1'b1, 1, acc);
      drain();
      checks++;
      if (alog.size() != 0) begin
         failures++;
         $display("FAIL misaligned_no_access: %0d memory cycles, required 0", alog.size());
      end
`endif
   endtask

   task automatic test_wrap_half();
      int acc;
      issue(1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h34, 1'b1, 32'h0, 1'b0, 2, acc);
      issue(1'b1, 2'b00, 1'b0, 32'h00000000, 32'h92, 1'b1, 32'h0, 1'b0, 2, acc);
      drain();
      alog.delete();
`ifdef LSU_MISALIGN_SPLIT_EN
      issue(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 32'hFFFF9234, 1'b0, 3, acc);
      drain();
      checks++;
      if (alog.size() != 2 || alog[0].addr !== 32'hFFFFFFFF || alog[1].addr !== 32'h0 ||
          alog[0].wr !== 1'b0 || alog[1].wr !== 1'b0 || alog[0].size !== 2'b00 || alog[1].size !== 2'b00) begin
         failures++;
         $display("FAIL wrap_beats: %0d beats first=%08h, required 2 byte reads ffffffff then 00000000",
                  alog.size(), alog.size() ? alog[0].addr : 32'h0);
      end
      issue(1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h00009234, 1'b0, 3, acc);
      drain();
`else
      issue(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1, acc);
      drain();
      checks++;
      if (alog.size() != 0) begin
         failures++;
         $display("FAIL wrap_no_access: %0d memory cycles, required 0", alog.size());
      end
`endif
   endtask

   task automatic test_illegal_size();
      int acc;
      alog.delete();
      issue(1'b1, 2'b11, 1'b0, 32'h40, 32'h55, 1'b1, 32'h0, 1'b1, 1, acc);
      checks += 2;
      if (req_ready !== 1'b0) begin failures++; $display("FAIL illegal_ready_low: got %0b, required 0", req_ready); end
      if (busy !== 1'b1)      begin failures++; $display("FAIL illegal_busy: got %0b, required 1", busy); end
      @(posedge clk);
      #1;
      checks += 2;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL illegal_ready_back: got %0b, required 1", req_ready); end
      if (busy !== 1'b0)      begin failures++; $display("FAIL illegal_idle: busy=%0b, required 0", busy); end
      issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1'b1, 1, acc);
      drain();
      checks++;
      if (alog.size() != 0) begin
         failures++;
         $display("FAIL illegal_no_access: %0d memory cycles, required 0", alog.size());
      end
   endtask

   task automatic test_back_to_back();
      int acc;
      logic [31:0] d [8];
      for (int i = 0; i < 8; i++) begin
         d[i] = $urandom;
         issue(1'b1, 2'b10, 1'b0, 32'h380 + 4 * i, d[i], 1'b1, 32'h0, 1'b0, 2, acc);
      end
      issue(1'b1, 2'b11, 1'b0, 32'h380, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1, 1, acc);
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, 2'b10, 1'b0, 32'h380 + 4 * i, 32'h0, 1'b1, d[i], 1'b0, 2, acc);
      end
      drain();
   endtask

   task automatic test_reset_abort();
      int acc;
      // aligned store aborted during its access cycle
      issue(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 2, acc);
      rst = 1'b1;
      #1;
      checks += 2;
      if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL abort_wr_en: got %0b, required 0", mem_wr_en); end
      if (busy !== 1'b0)      begin failures++; $display("FAIL abort_busy: got %0b, required 0", busy); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (mem_word(10'h300) !== 32'h0) begin
         failures++;
         $display("FAIL abort_no_write: word@300=%08h, required 00000000", mem_word(10'h300));
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h0, 1'b1, 32'h0, 1'b0, 2, acc);
      issue(1'b1, 2'b10, 1'b0, 32'h204, 32'h0, 1'b1, 32'h0, 1'b0, 2, acc);
      drain();
      issue(1'b1, 2'b10, 1'b0, 32'h201, 32'h11223344, 1'b0, 32'h0, 1'b0, 5, acc);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL split_abort_wr_en: got %0b, required 0", mem_wr_en); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (mem[10'h201] !== 8'h44 || mem[10'h202] !== 8'h33 || mem[10'h203] !== 8'h00 || mem[10'h204] !== 8'h00) begin
         failures++;
         $display("FAIL split_abort_mem: bytes 201..204=%02h %02h %02h %02h, required 44 33 00 00",
                  mem[10'h201], mem[10'h202], mem[10'h203], mem[10'h204]);
      end
`endif
      #1;
      checks += 2;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %0b, required 1", req_ready); end
      if (busy !== 1'b0)      begin failures++; $display("FAIL abort_idle: busy=%0b, required 0", busy); end
`ifdef LSU_MISALIGN_SPLIT_EN
      issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b1, 32'h00334400, 1'b0, 2, acc);
`else
      issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b1, 32'h00000000, 1'b0, 2, acc);
`endif
      drain();
   endtask

   initial begin
      test_reset();
      test_store_load_word();
      test_load_extend();
      test_misaligned_store();
      test_wrap_half();
      test_illegal_size();
      test_back_to_back();
      test_reset_abort();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the width of req_addr and mem_addr; data width SHALL be fixed at 32.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 req_valid  in  1  pipeline memory request present.
REQ-005 req_ready  out  1  request accepted on a clk edge where req_valid=1 and req_ready=1.
REQ-006 req_wr  in  1  1=store, 0=load.
REQ-007 req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-008 req_unsigned  in  1  load extension: 1=zero-extend, 0=sign-extend.
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle response strobe.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  out  1  valid with resp_valid; 1=illegal or rejected access.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.
REQ-015 mem_wr_en, mem_data_size[1:0], mem_addr[ADDR_W], mem_wr_data[32]  out  drive the data memory (write on clk edge, size encoding as req_size).
REQ-016 mem_rd_data  in  32  combinational read data, valid in the same cycle as mem_addr/mem_data_size.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, SPLIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 On acceptance, the module SHALL latch wr, size, unsigned, addr and wdata; later changes to req_* SHALL have no effect.
REQ-019 IDLE->RESP with resp_err=1 and no memory access SHALL occur when size=11.
REQ-020 Aligned (byte; half with addr[0]=0; word with addr[1:0]=0) requests SHALL go IDLE->ACCESS for exactly one cycle, then ->RESP.
REQ-021 In ACCESS: mem_addr=addr, mem_data_size=size, mem_wr_data=wdata, mem_wr_en=wr; for loads, mem_rd_data SHALL be captured at the end of that cycle.
REQ-022 Misaligned half/word requests SHALL follow the configuration selected by LSU_MISALIGN_SPLIT_EN (REQ-031/032).
REQ-023 In SPLIT beat k (k=0..N-1, N=2 for half, 4 for word): mem_addr=addr+k modulo 2^ADDR_W, mem_data_size=00, mem_wr_data[7:0]=wdata byte k (upper bits 0), mem_wr_en=wr; for loads, mem_rd_data[7:0] SHALL become result byte k.
REQ-024 After beat N-1, the FSM SHALL go to RESP.
REQ-025 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE.
REQ-026 Latency: aligned resp_valid SHALL occur 2 cycles after acceptance; split accesses SHALL give resp_valid N+1 cycles after acceptance; error responses SHALL occur 1 cycle after acceptance.
REQ-027 Load result SHALL be taken from the low byte, half or word of the captured data, zero- or sign-extended (sign from bit 7 or bit 15) per the latched unsigned bit; words SHALL pass unchanged.
REQ-028 Outside ACCESS/SPLIT: mem_wr_en=0, mem_addr=0, mem_wr_data=0, mem_data_size=10.

Reset
REQ-029 While rst=1: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, busy=0, all mem_* outputs=0 except mem_data_size=10, all latched request fields=0.
REQ-030 Reset asserted mid-access SHALL immediately force mem_wr_en=0, abort the request with no response, and leave memory contents written by completed beats unchanged.

Configuration
REQ-031 With LSU_MISALIGN_SPLIT_EN defined, misaligned half/word requests SHALL go IDLE->SPLIT and complete with resp_err=0.
REQ-032 Without LSU_MISALIGN_SPLIT_EN, misaligned half/word requests SHALL go IDLE->RESP with resp_err=1, resp_rdata=0 and no mem_wr_en pulse; the SPLIT state and byte-merge logic SHALL be absent.

Verification
REQ-033 Store word 0xDEADBEEF @0x100, then load word @0x100 -> one mem_wr_en cycle with size 10; load resp_rdata=0xDEADBEEF 2 cycles after acceptance, resp_err=0.
REQ-034 Memory byte @0x7=0x80: load byte signed -> 0xFFFFFF80; load byte unsigned -> 0x00000080.
REQ-035 Store word 0x11223344 @0x103 with macro defined -> byte writes 0x44, 0x33, 0x22, 0x11 at 0x103..0x106 in 4 consecutive cycles, resp_valid 5 cycles after acceptance; macro undefined -> no mem_wr_en, resp_err=1 after 1 cycle.
REQ-036 Load half @0xFFFFFFFF with macro defined, bytes 0x34@0xFFFFFFFF and 0x92@0x0 -> beat addresses 0xFFFFFFFF then 0x00000000; signed resp_rdata=0xFFFF9234.
REQ-037 req_size=11 -> resp_err=1, resp_rdata=0, no memory access; req_ready held 0 for 1 cycle.
REQ-038 rst asserted during beat 2 of a split store -> mem_wr_en drops in the same cycle, no resp_valid, bytes 0-1 remain written; after release req_ready=1 and busy=0.
